// File: rtl/rr_grant_scheduler_if.sv
// Handshake bundle between the round-robin scheduler and its requesters/downstream.
// The scheduler side uses the master modport.
interface rr_grant_scheduler_if #(
    parameter int IDX_WIDTH = 2
) ();
    localparam int NUM_REQ = 2 ** IDX_WIDTH;

    logic [NUM_REQ-1:0]   req;
    logic                 gnt_valid;
    logic [IDX_WIDTH-1:0] gnt_idx;
    logic [NUM_REQ-1:0]   gnt_onehot;
    logic                 gnt_ready;
    logic                 busy;

    modport master (
        input  req,
        input  gnt_ready,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot,
        output busy
    );

    modport slave (
        output req,
        output gnt_ready,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot,
        input  busy
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one sticky grant at a time, released on gnt_valid & gnt_ready.
// The grant is published as a registered index plus a decoded one-hot vector.

module decoder #(
    parameter int IDX_WIDTH = 2
) (
    input  logic [IDX_WIDTH-1:0]      idx,
    output logic [2**IDX_WIDTH-1:0]   onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < 2 ** IDX_WIDTH; i++) begin
            onehot[i] = (idx == IDX_WIDTH'(i));
        end
    end
endmodule

module rr_grant_scheduler #(
    parameter int IDX_WIDTH = 2
) (
    input logic                   clk,
    input logic                   arst,
    rr_grant_scheduler_if.master  bus
);
    localparam int NUM_REQ = 2 ** IDX_WIDTH;

    // state | meaning
    // IDLE  | no grant presented, waiting for any request
    // GRANT | gnt_idx presented and held until the handshake
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [IDX_WIDTH-1:0] ptr, ptr_n;
    logic [IDX_WIDTH-1:0] idx_q, idx_n;
    logic                 valid_q, valid_n;

    logic [IDX_WIDTH-1:0] base;
    logic [IDX_WIDTH-1:0] cand;
    logic [IDX_WIDTH-1:0] win;
    logic                 found;
    logic [NUM_REQ-1:0]   dec_onehot;

    // Search base: ptr when idle, the slot after the current winner during a handshake.
    always_comb begin
        base  = (state == GRANT) ? idx_q + 1'b1 : ptr;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = base + IDX_WIDTH'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx_q;
        valid_n = valid_q;
        case (state)
            IDLE: begin
                if (found) begin
                    idx_n   = win;
                    valid_n = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (bus.gnt_ready) begin
                    ptr_n = idx_q + 1'b1;
                    if (found) begin
                        idx_n = win;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            idx_q   <= idx_n;
            valid_q <= valid_n;
        end
    end

    decoder #(.IDX_WIDTH(IDX_WIDTH)) u_decoder (
        .idx    (idx_q),
        .onehot (dec_onehot)
    );

    assign bus.gnt_valid  = valid_q;
    assign bus.gnt_idx    = idx_q;
    assign bus.busy       = (state == GRANT);
    assign bus.gnt_onehot = valid_q ? dec_onehot : '0;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed scenarios plus random traffic checked against a behavioural round-robin model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rr_grant_scheduler;
    localparam int IW = 2;
    localparam int N  = 4;

    logic clk;
    logic arst;

    int checks;
    int errors;

    // reference model state
    int m_valid;
    int m_idx;
    int m_ptr;

    rr_grant_scheduler_if #(.IDX_WIDTH(IW)) bus_if ();

    rr_grant_scheduler #(.IDX_WIDTH(IW)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rdy);
        int w;
        if (m_valid == 0) begin
            w = model_pick(m_ptr, r);
            if (w >= 0) begin
                m_idx   = w;
                m_valid = 1;
            end
        end else if (rdy) begin
            m_ptr = (m_idx + 1) % N;
            w = model_pick(m_ptr, r);
            if (w >= 0) m_idx = w;
            else m_valid = 0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [N-1:0] exp_oh;
        logic         exp_v;
        logic [IW-1:0] exp_i;
        exp_v  = (m_valid != 0);
        exp_i  = IW'(m_idx);
        exp_oh = exp_v ? (N'(1) << m_idx) : '0;
        checks++;
        assert (bus_if.gnt_valid === exp_v) else begin
            errors++;
            $error("FAIL %s gnt_valid observed=%b expected=%b", tag, bus_if.gnt_valid, exp_v);
        end
        checks++;
        assert (bus_if.gnt_idx === exp_i) else begin
            errors++;
            $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, bus_if.gnt_idx, exp_i);
        end
        checks++;
        assert (bus_if.gnt_onehot === exp_oh) else begin
            errors++;
            $error("FAIL %s gnt_onehot observed=%b expected=%b", tag, bus_if.gnt_onehot, exp_oh);
        end
        checks++;
        assert (bus_if.busy === exp_v) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=%b", tag, bus_if.busy, exp_v);
        end
    endtask

    task automatic check_idx(input string tag, input int exp_i);
        checks++;
        assert (bus_if.gnt_valid === 1'b1 && bus_if.gnt_idx === IW'(exp_i)) else begin
            errors++;
            $error("FAIL %s valid/idx observed=%b/%0d expected=1/%0d", tag,
                   bus_if.gnt_valid, bus_if.gnt_idx, exp_i);
        end
    endtask

    // One clock: the model sees the inputs as they stood at the edge.
    task automatic step(input string tag);
        logic [N-1:0] r;
        logic rdy;
        r   = bus_if.req;
        rdy = bus_if.gnt_ready;
        @(posedge clk);
        if (arst) model_reset();
        else model_edge(r, rdy);
        #1;
        check_state(tag);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        arst = 1'b1;
        model_reset();
        #1;
        check_state("reset_pulse");
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        checks = 0;
        errors = 0;
        model_reset();
        arst             = 1'b1;
        bus_if.req       = '0;
        bus_if.gnt_ready = 1'b0;

        step("reset_hold");
        step("reset_hold");
        @(negedge clk);
        arst = 1'b0;
        step("idle_after_reset");

        // T1: async reset in the middle of a grant on requester 2
        bus_if.req = 4'b0100;
        step("t1_grant");
        step("t1_hold");
        check_idx("t1_pre_reset_idx", 2);
        #2;
        arst = 1'b1;
        model_reset();
        #1;
        check_state("t1_async_drop");
        @(negedge clk);
        arst = 1'b0;
        step("t1_regrant");
        check_idx("t1_regrant_idx", 2);
        bus_if.gnt_ready = 1'b1;
        bus_if.req       = '0;
        step("t1_drain");

        // T2: lone requester re-granted every cycle
        pulse_reset();
        bus_if.req       = 4'b0010;
        bus_if.gnt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step("t2_single");
            check_idx("t2_single_idx", 1);
        end

        // T3: full rotation from ptr=0
        pulse_reset();
        bus_if.req       = 4'b1111;
        bus_if.gnt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step("t3_rotate");
            check_idx("t3_rotate_idx", exp_seq[c]);
        end

        // T4: hold and sticky grant, then wrap (T5) and drain (T6)
        pulse_reset();
        bus_if.req       = 4'b1001;
        bus_if.gnt_ready = 1'b0;
        step("t4_grant");
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus_if.req = 4'b1000;
            step("t4_hold");
            check_idx("t4_hold_idx", 0);
        end
        bus_if.gnt_ready = 1'b1;
        step("t4_next");
        check_idx("t4_next_idx", 3);
        bus_if.req = 4'b1010;
        step("t5_wrap_a");
        check_idx("t5_wrap_a_idx", 1);
        step("t5_wrap_b");
        check_idx("t5_wrap_b_idx", 3);
        bus_if.req = '0;
        step("t6_drain");
        step("t6_idle");
        step("t6_idle");
        bus_if.req = 4'b0100;
        step("t6_regrant");
        check_idx("t6_regrant_idx", 2);

        // random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            bus_if.req       = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15) | 4'h3);
            bus_if.gnt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
